// File: rtl/led_pattern_sched.sv
// led_pattern_sched: round-robin scheduler sharing a 4-bit LED bank between NUM_REQ requesters.
// Optional feature: define LED_SCHED_PREEMPT_EN to give requester 0 absolute priority and
// let it abort another requester's SHOW or any GAP.
module led_pattern_sched #(
    parameter int CLK_DIV   = 50000,
    parameter int NUM_REQ   = 4,
    parameter int DWELL_W   = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [4*NUM_REQ-1:0]       req_pattern,
    input  logic [DWELL_W*NUM_REQ-1:0] req_dwell,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [3:0]                 leds,
    output logic                       busy
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GAP_TICKS + 2);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_in;
    logic [GW-1:0]      gap_q, gap_d;
    logic [IW-1:0]      last_q, last_d, pick, sel, idx;
    logic [3:0]         pat_q, pat_d, pat_in, leds_q, leds_d;
    logic [NUM_REQ-1:0] ack_q, ack_d, done_q, done_d, cand;
    logic               tick, grant, preempt, finish, gap_end;

    assign tick    = pre_q == PW'(CLK_DIV - 1);
    assign finish  = state_q == SHOW && tick && dwell_q == DWELL_W'(1);
    assign gap_end = state_q == GAP && tick && gap_q == GW'(1);

    // Arbitration: round-robin pick after last grant, optional requester-0 override, operand mux
    always_comb begin
        cand = req;
`ifdef LED_SCHED_PREEMPT_EN
        cand[0] = 1'b0;
`endif
        pick = last_q;
        idx  = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (cand[idx]) pick = idx;
        end
`ifdef LED_SCHED_PREEMPT_EN
        preempt = req[0] && ((state_q == SHOW && last_q != '0) || state_q == GAP);
        sel     = req[0] ? '0 : pick;
`else
        preempt = 1'b0;
        sel     = pick;
`endif
        grant    = preempt || (state_q == IDLE && |req);
        dwell_in = '0;
        pat_in   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IW'(i)) begin
                dwell_in = req_dwell[i*DWELL_W +: DWELL_W];
                pat_in   = req_pattern[i*4 +: 4];
            end
        end
    end

    // Next state: latch on grant, count dwell and gap ticks, restart prescaler on every entry
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        pat_d   = pat_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        if (grant) begin
            state_d = SHOW;
            last_d  = sel;
            pat_d   = pat_in;
            dwell_d = dwell_in | DWELL_W'(dwell_in == '0);
        end else if (finish) begin
            state_d = (GAP_TICKS > 0) ? GAP : IDLE;
            gap_d   = GW'(GAP_TICKS);
        end else if (gap_end) begin
            state_d = IDLE;
        end else if (tick) begin
            dwell_d = (state_q == SHOW) ? dwell_q - 1'b1 : dwell_q;
            gap_d   = (state_q == GAP) ? gap_q - 1'b1 : gap_q;
        end
        pre_d = (grant || state_d != state_q || state_q == IDLE || tick) ? '0 : pre_q + 1'b1;
    end

    // Outputs: ack on grant, done only for a display that ran to completion
    always_comb begin
        ack_d  = '0;
        done_d = '0;
        if (grant) ack_d[sel] = 1'b1;
        if (finish && !grant) done_d[last_q] = 1'b1;
        leds_d = (state_d == SHOW) ? pat_d : 4'h0;
        busy   = state_q != IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers; last grant resets to NUM_REQ-1 so requester 0 goes first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            dwell_q <= '0;
            gap_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            pat_q   <= '0;
            leds_q  <= '0;
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            pat_q   <= pat_d;
            leds_q  <= leds_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign ack  = ack_q;
    assign done = done_q;
    assign leds = leds_q;
endmodule
